ps2_lane_judge: RTL and testbench

Input-judging stage directly upstream of `controlModule`. It decodes the arrow-key byte stream from the PS/2 controller into lane presses. On each `check_input_go` request it compares the first new press against the lane of the bottom tile row (`line_6`). It returns one-cycle `correct` / `incorrect` verdicts plus `check_input_done`, which drive the control FSM, the score counter and the shift stage.

---
 rtl/ps2_pkg.sv | 62 ++++++
 rtl/ps2_arrow_decoder.sv | 83 ++++++++
 rtl/ps2_lane_judge.sv | 120 ++++++++++++
 tb/tb_ps2_lane_judge.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 arrow-key lane judge: scancodes, lane codes,
// FSM state encodings and small lane helpers.
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam logic [2:0] LANE_NONE  = 3'd0;
    localparam logic [2:0] LANE_LEFT  = 3'd1;
    localparam logic [2:0] LANE_DOWN  = 3'd2;
    localparam logic [2:0] LANE_UP    = 3'd3;
    localparam logic [2:0] LANE_RIGHT = 3'd4;

    typedef enum logic [1:0] {
        P_IDLE    = 2'd0,
        P_EXT     = 2'd1,
        P_EXT_BRK = 2'd2,
        P_BRK     = 2'd3
    } parse_state_e;

    typedef enum logic [1:0] {
        J_IDLE    = 2'd0,
        J_WAIT    = 2'd1,
        J_DONE    = 2'd2,
        J_RELEASE = 2'd3
    } judge_state_e;

    // Extended scancode (the byte after E0) to lane; non-arrow codes give LANE_NONE.
    function automatic logic [2:0] scan_to_lane(input logic [7:0] code);
        logic [2:0] lane;
        case (code)
            SC_LEFT:  lane = LANE_LEFT;
            SC_DOWN:  lane = LANE_DOWN;
            SC_UP:    lane = LANE_UP;
            SC_RIGHT: lane = LANE_RIGHT;
            default:  lane = LANE_NONE;
        endcase
        return lane;
    endfunction

    // One-hot keys_held bit for a lane: bit0 = left ... bit3 = right.
    function automatic logic [3:0] lane_mask(input logic [2:0] lane);
        logic [3:0] mask;
        case (lane)
            LANE_LEFT:  mask = 4'b0001;
            LANE_DOWN:  mask = 4'b0010;
            LANE_UP:    mask = 4'b0100;
            LANE_RIGHT: mask = 4'b1000;
            default:    mask = 4'b0000;
        endcase
        return mask;
    endfunction

    function automatic logic [2:0] sanitize_lane(input logic [2:0] raw);
        return (raw > LANE_RIGHT) ? LANE_NONE : raw;
    endfunction

endpackage

// File: rtl/ps2_arrow_decoder.sv
// PS/2 byte-stream parser: tracks held arrow keys and emits a one-cycle press
// event on the first make of each key (typematic repeats are suppressed).
module ps2_arrow_decoder
    import ps2_pkg::*;
(
    input  logic         clock,
    input  logic         resetn,
    input  logic [7:0]   ps2_byte,
    input  logic         ps2_byte_en,
    output logic [3:0]   keys_held,
    output logic         press_evt,
    output logic [2:0]   press_lane,
    output parse_state_e parse_state
);

    parse_state_e state_q, state_d;
    logic [3:0]   keys_q, keys_d;
    logic         evt_q, evt_d;
    logic [2:0]   lane_q, lane_d;
    logic [2:0]   byte_lane;
    logic [3:0]   byte_mask;

    assign byte_lane = scan_to_lane(ps2_byte);
    assign byte_mask = lane_mask(byte_lane);

    always_comb begin
        state_d = state_q;
        keys_d  = keys_q;
        evt_d   = 1'b0;
        lane_d  = lane_q;
        if (ps2_byte_en) begin
            unique case (state_q)
                P_IDLE: begin
                    if (ps2_byte == SC_EXT)      state_d = P_EXT;
                    else if (ps2_byte == SC_BRK) state_d = P_BRK;
                    else                         state_d = P_IDLE;
                end
                P_EXT: begin
                    if (ps2_byte == SC_BRK)      state_d = P_EXT_BRK;
                    else if (ps2_byte == SC_EXT) state_d = P_EXT;
                    else begin
                        state_d = P_IDLE;
                        keys_d  = keys_q | byte_mask;
                        // Only a clear-to-set transition counts as a press.
                        if (byte_lane != LANE_NONE && (keys_q & byte_mask) == 4'b0000) begin
                            evt_d  = 1'b1;
                            lane_d = byte_lane;
                        end
                    end
                end
                P_EXT_BRK: begin
                    state_d = (ps2_byte == SC_EXT) ? P_EXT : P_IDLE;
                    keys_d  = keys_q & ~byte_mask;
                end
                P_BRK: begin
                    // A plain break consumes exactly one byte, whatever it is.
                    state_d = P_IDLE;
                end
                default: state_d = P_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= P_IDLE;
            keys_q  <= 4'b0000;
            evt_q   <= 1'b0;
            lane_q  <= LANE_NONE;
        end else begin
            state_q <= state_d;
            keys_q  <= keys_d;
            evt_q   <= evt_d;
            lane_q  <= lane_d;
        end
    end

    assign keys_held   = keys_q;
    assign press_evt   = evt_q;
    assign press_lane  = lane_q;
    assign parse_state = state_q;

endmodule

// File: rtl/ps2_lane_judge.sv
// Lane judge: on each go request, compares the first new arrow press against
// the bottom tile row and returns a one-cycle correct/incorrect verdict.
module ps2_lane_judge
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 25_000_000
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic [7:0]   ps2_byte,
    input  logic         ps2_byte_en,
    input  logic         check_input_go,
    input  logic [2:0]   line_6,
    output logic         correct,
    output logic         incorrect,
    output logic         check_input_done,
    output logic [3:0]   keys_held,
    output logic         judge_busy,
    output parse_state_e parse_state_dbg,
    output judge_state_e judge_state_dbg
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);

    logic         press_evt;
    logic [2:0]   press_lane;

    judge_state_e state_q, state_d;
    logic [2:0]   tgt_q, tgt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic         expired_q, expired_d;
    logic         correct_q, correct_d;
    logic         incorrect_q, incorrect_d;
    logic         done_q, done_d;

    ps2_arrow_decoder u_decoder (
        .clock       (clock),
        .resetn      (resetn),
        .ps2_byte    (ps2_byte),
        .ps2_byte_en (ps2_byte_en),
        .keys_held   (keys_held),
        .press_evt   (press_evt),
        .press_lane  (press_lane),
        .parse_state (parse_state_dbg)
    );

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        timer_d     = timer_q;
        expired_d   = 1'b0;
        correct_d   = 1'b0;
        incorrect_d = 1'b0;
        done_d      = 1'b0;
        unique case (state_q)
            J_IDLE: begin
                if (check_input_go) begin
                    tgt_d   = sanitize_lane(line_6);
                    timer_d = TIMER_LOAD;
                    state_d = J_WAIT;
                end
            end
            J_WAIT: begin
                timer_d = (timer_q != '0) ? timer_q - TW'(1) : '0;
                if (!check_input_go) begin
                    state_d = J_IDLE;
                end else if (press_evt) begin
                    // Presses beat the timeout; tgt of LANE_NONE never matches a lane.
                    correct_d   = (press_lane == tgt_q);
                    incorrect_d = (press_lane != tgt_q);
                    done_d      = 1'b1;
                    state_d     = J_DONE;
                end else if (expired_q) begin
                    correct_d   = (tgt_q == LANE_NONE);
                    incorrect_d = (tgt_q != LANE_NONE);
                    done_d      = 1'b1;
                    state_d     = J_DONE;
                end else begin
                    // Zero is seen one cycle before the miss verdict is taken.
                    expired_d = (timer_q == '0);
                end
            end
            J_DONE: begin
                state_d = J_RELEASE;
            end
            J_RELEASE: begin
                if (!check_input_go) state_d = J_IDLE;
            end
            default: state_d = J_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= J_IDLE;
            tgt_q       <= LANE_NONE;
            timer_q     <= '0;
            expired_q   <= 1'b0;
            correct_q   <= 1'b0;
            incorrect_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            timer_q     <= timer_d;
            expired_q   <= expired_d;
            correct_q   <= correct_d;
            incorrect_q <= incorrect_d;
            done_q      <= done_d;
        end
    end

    assign correct          = correct_q;
    assign incorrect        = incorrect_q;
    assign check_input_done = done_q;
    assign judge_busy       = (state_q == J_WAIT);
    assign judge_state_dbg  = state_q;

endmodule

// File: tb/tb_ps2_lane_judge.sv
// Self-checking bench for ps2_lane_judge: vector table, hand-written corner
// sequences and randomized windows against a lane-level reference model.
module tb_ps2_lane_judge;
    import ps2_pkg::*;

    localparam int T = 100;

    logic         clock;
    logic         resetn;
    logic [7:0]   ps2_byte;
    logic         ps2_byte_en;
    logic         check_input_go;
    logic [2:0]   line_6;
    logic         correct;
    logic         incorrect;
    logic         check_input_done;
    logic [3:0]   keys_held;
    logic         judge_busy;
    parse_state_e parse_state_dbg;
    judge_state_e judge_state_dbg;

    int n_cmp  = 0;
    int n_fail = 0;

    ps2_lane_judge #(.TIMEOUT_CYCLES(T)) dut (
        .clock            (clock),
        .resetn           (resetn),
        .ps2_byte         (ps2_byte),
        .ps2_byte_en      (ps2_byte_en),
        .check_input_go   (check_input_go),
        .line_6           (line_6),
        .correct          (correct),
        .incorrect        (incorrect),
        .check_input_done (check_input_done),
        .keys_held        (keys_held),
        .judge_busy       (judge_busy),
        .parse_state_dbg  (parse_state_dbg),
        .judge_state_dbg  (judge_state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] line;
        logic [2:0] lane;
        logic       exp_correct;
        logic [3:0] exp_keys;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] lane_code(input logic [2:0] lane);
        case (lane)
            3'd1:    return 8'h6B;
            3'd2:    return 8'h72;
            3'd3:    return 8'h75;
            default: return 8'h74;
        endcase
    endfunction

    task automatic send_byte(input logic [7:0] b);
        ps2_byte    = b;
        ps2_byte_en = 1'b1;
        tick();
        ps2_byte_en = 1'b0;
    endtask

    task automatic send_make(input logic [2:0] lane);
        send_byte(8'hE0);
        send_byte(lane_code(lane));
    endtask

    task automatic send_break(input logic [2:0] lane);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(lane_code(lane));
    endtask

    task automatic open_window(input logic [2:0] line);
        line_6         = line;
        check_input_go = 1'b1;
        tick();
    endtask

    task automatic wait_done(input int budget, output int cycles, output bit seen);
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            tick();
            cycles++;
            if (check_input_done) seen = 1'b1;
        end
    endtask

    // Reference model: which lanes are currently held, tracked per lane.
    bit   held[1:4];
    logic [3:0] model_keys;

    function automatic logic [3:0] held_vec();
        logic [3:0] v;
        for (int l = 1; l <= 4; l++) v[l-1] = held[l];
        return v;
    endfunction

    initial begin
        int  cyc;
        bit  seen;
        int  pulses;
        logic [2:0] tgt, lane;
        logic exp_ok;
        int  act;

        vecs[0] = '{3'd3, 3'd3, 1'b1, 4'b0100};
        vecs[1] = '{3'd1, 3'd4, 1'b0, 4'b1000};
        vecs[2] = '{3'd2, 3'd0, 1'b0, 4'b0000};
        vecs[3] = '{3'd0, 3'd0, 1'b1, 4'b0000};
        vecs[4] = '{3'd0, 3'd2, 1'b0, 4'b0010};
        vecs[5] = '{3'd4, 3'd4, 1'b1, 4'b1000};
        vecs[6] = '{3'd6, 3'd0, 1'b1, 4'b0000};
        vecs[7] = '{3'd7, 3'd1, 1'b0, 4'b0001};
        vecs[8] = '{3'd2, 3'd2, 1'b1, 4'b0010};
        vecs[9] = '{3'd1, 3'd0, 1'b0, 4'b0000};

        resetn         = 1'b0;
        ps2_byte       = 8'h00;
        ps2_byte_en    = 1'b0;
        check_input_go = 1'b0;
        line_6         = 3'd0;
        repeat (3) tick();
        check("reset_correct", {31'd0, correct}, 0);
        check("reset_incorrect", {31'd0, incorrect}, 0);
        check("reset_done", {31'd0, check_input_done}, 0);
        check("reset_keys", {28'd0, keys_held}, 0);
        check("reset_busy", {31'd0, judge_busy}, 0);
        resetn = 1'b1;
        tick();

        // Table-driven windows: press path timing and timeout path timing.
        for (int i = 0; i < 10; i++) begin
            open_window(vecs[i].line);
            check("vec_busy", {31'd0, judge_busy}, 1);
            if (vecs[i].lane != 3'd0) begin
                send_make(vecs[i].lane);
                check("vec_early_done", {31'd0, check_input_done}, 0);
                tick();
            end else begin
                repeat (T) tick();
                check("vec_early_done", {31'd0, check_input_done}, 0);
                tick();
            end
            check("vec_done", {31'd0, check_input_done}, 1);
            check("vec_correct", {31'd0, correct}, {31'd0, vecs[i].exp_correct});
            check("vec_incorrect", {31'd0, incorrect}, {31'd0, ~vecs[i].exp_correct});
            check("vec_keys", {28'd0, keys_held}, {28'd0, vecs[i].exp_keys});
            tick();
            check("vec_done_pulse", {31'd0, check_input_done | correct | incorrect}, 0);
            check("vec_busy_after", {31'd0, judge_busy}, 0);
            check_input_go = 1'b0;
            if (vecs[i].lane != 3'd0) begin
                send_break(vecs[i].lane);
                check("vec_release_no_pulse", {31'd0, check_input_done}, 0);
                check("vec_keys_released", {28'd0, keys_held}, 0);
            end
            tick();
        end

        // Held go: exactly one verdict; typematic repeats raise no new press.
        open_window(3'd1);
        send_make(3'd1);
        tick();
        check("hold_first_correct", {31'd0, correct}, 1);
        pulses = 0;
        for (int c = 0; c < 500; c++) begin
            if (c % 100 == 10) send_make(3'd1);
            else tick();
            if (check_input_done) pulses++;
        end
        check("hold_extra_pulses", pulses, 0);
        check_input_go = 1'b0;
        tick();
        tick();
        open_window(3'd1);
        send_make(3'd1);
        wait_done(2 * T, cyc, seen);
        check("typematic_seen", {31'd0, seen}, 1);
        check("typematic_latency", cyc + 2, T + 1);
        check("typematic_incorrect", {31'd0, incorrect}, 1);
        check_input_go = 1'b0;
        send_break(3'd1);
        tick();

        // Non-extended make/break noise before the real press.
        open_window(3'd1);
        pulses = 0;
        send_byte(8'h1C);
        if (check_input_done) pulses++;
        send_byte(8'hF0);
        if (check_input_done) pulses++;
        send_byte(8'h1C);
        if (check_input_done) pulses++;
        send_make(3'd1);
        if (check_input_done) pulses++;
        tick();
        if (check_input_done) pulses++;
        check("noise_correct", {31'd0, correct}, 1);
        check("noise_keys", {28'd0, keys_held}, 4'b0001);
        tick();
        if (check_input_done) pulses++;
        check("noise_single_pulse", pulses, 1);
        check_input_go = 1'b0;
        tick();

        // Abort: dropping go mid-window gives no verdict.
        open_window(3'd2);
        repeat (5) tick();
        check_input_go = 1'b0;
        tick();
        check("abort_busy", {31'd0, judge_busy}, 0);
        wait_done(T + 20, cyc, seen);
        check("abort_no_done", {31'd0, seen}, 0);

        // Asynchronous reset mid-window and mid-E0, left key still held.
        open_window(3'd2);
        send_byte(8'hE0);
        resetn = 1'b0;
        #1;
        check("rst_keys", {28'd0, keys_held}, 0);
        check("rst_busy", {31'd0, judge_busy}, 0);
        check("rst_outs", {29'd0, correct, incorrect, check_input_done}, 0);
        check_input_go = 1'b0;
        #2;
        resetn = 1'b1;
        tick();
        open_window(3'd1);
        send_make(3'd1);
        tick();
        check("post_rst_correct", {31'd0, correct}, 1);
        check_input_go = 1'b0;
        send_break(3'd1);
        tick();

        // Randomized windows against the lane-level model.
        for (int l = 1; l <= 4; l++) held[l] = 1'b0;
        for (int e = 0; e < 40; e++) begin
            line_6 = 3'($urandom_range(0, 7));
            tgt    = (line_6 > 3'd4) ? 3'd0 : line_6;
            act    = $urandom_range(0, 2);
            exp_ok = (tgt == 3'd0);
            open_window(line_6);
            repeat ($urandom_range(0, 10)) tick();
            if (act == 1) begin
                lane = 3'($urandom_range(1, 4));
                if (!held[lane]) exp_ok = (lane == tgt);
                held[lane] = 1'b1;
                send_make(lane);
            end else if (act == 2) begin
                if ($urandom_range(0, 1) == 1) send_byte(8'hF0);
                send_byte(8'($urandom_range(16, 95)));
            end
            wait_done(2 * T + 20, cyc, seen);
            check("rnd_done_seen", {31'd0, seen}, 1);
            if (seen) begin
                check("rnd_correct", {31'd0, correct}, {31'd0, exp_ok});
                check("rnd_incorrect", {31'd0, incorrect}, {31'd0, ~exp_ok});
            end
            model_keys = held_vec();
            check("rnd_keys", {28'd0, keys_held}, {28'd0, model_keys});
            check_input_go = 1'b0;
            tick();
            if ($urandom_range(0, 2) == 0) begin
                lane = 3'($urandom_range(1, 4));
                held[lane] = 1'b0;
                send_break(lane);
            end else if ($urandom_range(0, 3) == 0) begin
                lane = 3'($urandom_range(1, 4));
                held[lane] = 1'b1;
                send_make(lane);
            end
            tick();
            model_keys = held_vec();
            check("rnd_keys_between", {28'd0, keys_held}, {28'd0, model_keys});
            check("rnd_idle_no_done", {31'd0, check_input_done}, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
